// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit and its load-alignment helper:
//   - lsu_state_t : access FSM states (IDLE, REQ, RESP)
//   - F3_*        : RV32I funct3 width/sign codes
//   - helpers     : byte-enable, store-lane replication and alignment check
// Codes other than B/BU/H/HU (including the undefined 011, 110, 111) behave
// as a full word.
// -----------------------------------------------------------------------------
package lsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } lsu_state_t;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic lsu_is_byte(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_BU);
    endfunction

    function automatic logic lsu_is_half(input logic [2:0] f3);
        return (f3 == F3_H) || (f3 == F3_HU);
    endfunction

    // Halfword lane is chosen by off[1] only, so a misaligned halfword
    // (when not trapped) still lands on a legal lane pair.
    function automatic logic [3:0] lsu_be(input logic [2:0] f3, input logic [1:0] off);
        if (lsu_is_byte(f3)) begin
            return 4'b0001 << off;
        end
        if (lsu_is_half(f3)) begin
            return off[1] ? 4'b1100 : 4'b0011;
        end
        return 4'b1111;
    endfunction

    // Store data is replicated on every lane so the byte enables alone
    // select what the memory writes.
    function automatic logic [31:0] lsu_wdata(input logic [2:0] f3, input logic [31:0] wd);
        if (lsu_is_byte(f3)) begin
            return {4{wd[7:0]}};
        end
        if (lsu_is_half(f3)) begin
            return {2{wd[15:0]}};
        end
        return wd;
    endfunction

    function automatic logic lsu_misaligned(input logic [2:0] f3, input logic [1:0] off);
        if (lsu_is_byte(f3)) begin
            return 1'b0;
        end
        if (lsu_is_half(f3)) begin
            return off[0];
        end
        return off != 2'b00;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// -----------------------------------------------------------------------------
// lsu_load_align
// Purely combinational load-data extraction: selects the addressed byte or
// halfword from a 32-bit read word and sign/zero-extends it.
// Ports:
//   rdata  in  32  raw read word from memory
//   offset in  2   byte offset within the word (addr[1:0])
//   funct3 in  3   width/sign code
//   result out 32  extended load value
// -----------------------------------------------------------------------------
module lsu_load_align
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata[{offset, 3'b000} +: 8];
        half_sel = rdata[{offset[1], 4'b0000} +: 16];
        case (funct3)
            F3_B:    result = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   result = {24'h000000, byte_sel};
            F3_H:    result = {{16{half_sel[15]}}, half_sel};
            F3_HU:   result = {16'h0000, half_sel};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Initiator side of the data-memory interface. Accepts one load/store per
// handshake, issues a word-aligned request with byte enables, waits for grant
// (and read data for loads), then returns the aligned/extended load result.
// Optional feature macro: LSU_MISALIGN_TRAP_EN -- misaligned accesses issue no
// request and pulse err instead; undefined, err is tied low.
// Ports:
//   clk, n_rst                           clock, async active-low reset
//   ex_valid, ex_ready, MemRead, MemWr   execute-stage handshake
//   funct3, addr, write_data, rd         access description
//   mem_req/we/addr/be/wdata, mem_gnt    memory request channel
//   mem_rvalid, mem_rdata                memory read response
//   wb_valid, wb_data, wb_rd             writeback of completed loads
//   stall, err                           pipeline stall, misalign pulse
// -----------------------------------------------------------------------------
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TAG_W  = 5,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              ex_valid,
    output logic              ex_ready,
    input  logic              MemRead,
    input  logic              MemWr,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       write_data,
    input  logic [TAG_W-1:0]  rd,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_be,
    output logic [31:0]       mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata,
    output logic              wb_valid,
    output logic [31:0]       wb_data,
    output logic [TAG_W-1:0]  wb_rd,
    output logic              stall,
    output logic              err
);

    lsu_state_t        state_q, state_d;
    logic              active_q;     // low only until the first clock after reset
    logic              we_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic [TAG_W-1:0]  rd_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [3:0]        mem_be_q;
    logic [31:0]       mem_wdata_q;
    logic              wb_valid_q;
    logic [31:0]       wb_data_q;
    logic [TAG_W-1:0]  wb_rd_q;
    logic              err_q;

    logic              accept;
    logic              misalign;
    logic              capture;
    logic [31:0]       load_value;

    assign accept = ex_valid && ex_ready && (MemRead || MemWr);

`ifdef LSU_MISALIGN_TRAP_EN
    assign misalign = lsu_misaligned(funct3, addr[1:0]);
`else
    assign misalign = 1'b0;
`endif

    // Read data is only meaningful for a load that has been (or is being)
    // granted; anything else on mem_rvalid is stale and dropped.
    assign capture = !we_q && mem_rvalid &&
                     (((state_q == REQ) && mem_gnt) || (state_q == RESP));

    lsu_load_align u_load_align (
        .rdata  (mem_rdata),
        .offset (off_q),
        .funct3 (f3_q),
        .result (load_value)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept && !misalign) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    if (we_q || mem_rvalid) begin
                        state_d = IDLE;
                    end else begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                if (mem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            active_q    <= 1'b0;
            we_q        <= 1'b0;
            f3_q        <= 3'b000;
            off_q       <= 2'b00;
            rd_q        <= '0;
            mem_addr_q  <= '0;
            mem_be_q    <= 4'b0000;
            mem_wdata_q <= 32'h0;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= 32'h0;
            wb_rd_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            active_q   <= 1'b1;
            wb_valid_q <= capture;
            err_q      <= accept && misalign;
            // Request fields are frozen at acceptance so they stay stable
            // through any number of grant wait cycles.
            if (accept && !misalign) begin
                we_q        <= MemWr;
                f3_q        <= funct3;
                off_q       <= addr[1:0];
                rd_q        <= rd;
                mem_addr_q  <= {addr[ADDR_W-1:2], 2'b00};
                mem_be_q    <= lsu_be(funct3, addr[1:0]);
                mem_wdata_q <= lsu_wdata(funct3, write_data);
            end
            if (capture) begin
                wb_data_q <= load_value;
                wb_rd_q   <= rd_q;
            end
        end
    end

    assign ex_ready  = active_q && (state_q == IDLE);
    assign stall     = ex_valid && !ex_ready;
    assign mem_req   = (state_q == REQ);
    assign mem_we    = we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;
    assign wb_valid  = wb_valid_q;
    assign wb_data   = wb_data_q;
    assign wb_rd     = wb_rd_q;
    assign err       = err_q;

endmodule
